stage3_load_scoreboard: RTL
===========================

# stage3_load_scoreboard

Producer-side companion to the stage-3 forwarding logic. It tracks destination registers of in-flight long-latency writes (loads, multi-cycle ops) from issue until completion. It tells the execute stage whether each source operand must stall or can be forwarded from the completing result. It sits beside the execute/mem boundary: issue events come from execute, in-order completions come from the memory/writeback side.

## Interface
Parameters:
- `DEPTH`, 4: maximum outstanding long-latency writes; power of two, ≥2.
- `NREGS`, 32: architectural integer registers; register 0 is hardwired zero.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  long-latency op with a destination leaves execute this cycle.
- `issue_rd`  in  5  destination register of the issuing op.
- `issue_ready`  out  1  space available; issue is accepted only when `issue_valid && issue_ready`.
- `cpl_valid`  in  1  oldest outstanding op completes this cycle; its result is on `cpl_data`.
- `cpl_data`  in  32  completing result.
- `cpl_rd`  out  5  destination of the oldest outstanding op (FIFO head); 0 when empty.
- `rs1_e`, `rs2_e`  in  5 each  execute-stage source registers.
- `stall_rs1`, `stall_rs2`  out  1 each  operand not yet available.
- `fwd_rs1`, `fwd_rs2`  out  1 each  operand supplied this cycle by `fwd_data`.
- `fwd_data`  out  32  equals `cpl_data` (combinational pass-through).
- `occupancy`  out  $clog2(DEPTH+1)  outstanding entries.
- `underflow`  out  1  sticky: `cpl_valid` arrived while empty.

## Operation
- Completion-order FIFO of `DEPTH` destination registers. Completions are strictly in issue order.
- Per-register pending counter, width $clog2(DEPTH+1). A counter above 1 means multiple WAW writes are outstanding.
- Accepted issue: push `issue_rd`. If `issue_rd != 0`, increment `pend[issue_rd]`.
- `cpl_valid` with non-empty FIFO: pop head. If the head rd is not 0, decrement `pend[head]`.
- Issue and completion in the same cycle: push and pop both happen and occupancy is unchanged. If both target the same rd, its counter is unchanged.
- `issue_ready = (occupancy != DEPTH)`. This uses the registered count only; a same-cycle completion does not free space for a same-cycle issue.
- Operand rules, evaluated for each of rs1/rs2 (shown for rs):
  - rs == 0: stall=0, fwd=0.
  - `pend[rs]==0`: stall=0, fwd=0.
  - `cpl_valid && cpl_rd==rs && pend[rs]==1`: stall=0, fwd=1.
  - otherwise: stall=1, fwd=0. This includes the case where the head matches but a younger write to rs is still pending.
- `stall_*` and `fwd_*` are never both 1.
- `cpl_valid` when empty: no state change; set `underflow`, which clears only on reset.
- An issue that arrives while full is ignored. It is the issuer's responsibility, so no error is flagged.

## Timing
- An accepted issue affects `pend`, `stall_*`, `occupancy` and `cpl_rd` starting the next cycle.
- A completion clears its entry starting the next cycle. The same-cycle forward path covers the completion cycle itself.
- `stall_*`, `fwd_*`, `fwd_data` and `cpl_rd` are combinational from registered state and the current inputs. There is no added latency.
- Reset (including mid-operation) clears the FIFO, all counters and `underflow`. Outstanding completions are forgotten.
- Reset values: `issue_ready`=1, `cpl_rd`=0, `stall_*`=0, `fwd_*`=0, `occupancy`=0, `underflow`=0. `fwd_data` follows `cpl_data`.
- Head/tail pointers are $clog2(DEPTH) bits and wrap naturally. Full versus empty is distinguished by the occupancy counter.

## Structure
- Shared stage-3 package holds `regidx_t` (5-bit), `word_t` (32-bit) and the default `SCOREBOARD_DEPTH`.
- One natural sub-module, `stage3_rd_fifo`: a parameterised in-order FIFO of `regidx_t` with push/pop, head, occupancy and full.
- The pending-counter array and operand-check logic stay in the top module.

## Test plan
- Issue rd=5, idle 1 cycle, check `rs1_e`=5 → `stall_rs1`=1. Then `cpl_valid` with `cpl_data`=0xDEADBEEF → `fwd_rs1`=1, `fwd_data`=0xDEADBEEF, `stall_rs1`=0. Next cycle → both 0, `occupancy`=0.
- WAW: issue rd=7 twice, then complete the first with `rs2_e`=7 → `stall_rs2`=1, `fwd_rs2`=0. Complete the second → `fwd_rs2`=1.
- Fill 4 entries → `issue_ready`=0, `occupancy`=4. Issue + complete in the same cycle → the issue is ignored and `occupancy`=3. Then issue → accepted, `occupancy`=4.
- Issue rd=0, then `rs1_e`=0 → no stall. Complete → `cpl_rd` was 0, `occupancy` returns to 0.
- Simultaneous issue rd=3 and completion of rd=3 with `pend[3]`=1 → `fwd_rs1`=1 for `rs1_e`=3 this cycle. Next cycle `pend[3]`=1 → `stall_rs1`=1.
- `cpl_valid` while empty → `underflow`=1 and held. Then assert `RST` with 2 entries outstanding → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/stage3_load_scoreboard_pkg.sv
// Shared stage-3 types, the default scoreboard depth and the operand check helper.
package stage3_load_scoreboard_pkg;

    typedef logic [4:0]  regidx_t;
    typedef logic [31:0] word_t;

    localparam int SCOREBOARD_DEPTH = 4;

    // Returns {stall, fwd} for one source operand.
    // The forward case only applies when the completing write is the last one
    // still outstanding to this register; otherwise a younger write must win.
    function automatic logic [1:0] operand_status(input regidx_t rs,
                                                  input logic    pend_zero,
                                                  input logic    pend_one,
                                                  input logic    cpl_hit);
        logic [1:0] status;
        if (rs == '0 || pend_zero) begin
            status = 2'b00;
        end else if (cpl_hit && pend_one) begin
            status = 2'b01;
        end else begin
            status = 2'b10;
        end
        return status;
    endfunction

endpackage

// File: rtl/stage3_load_scoreboard_if.sv
// Issue and completion handshake between execute, memory/writeback and the scoreboard.
interface stage3_load_scoreboard_if;
    import stage3_load_scoreboard_pkg::*;

    logic    issue_valid;
    regidx_t issue_rd;
    logic    issue_ready;
    logic    cpl_valid;
    word_t   cpl_data;
    regidx_t cpl_rd;

    modport master (
        output issue_valid, issue_rd, cpl_valid, cpl_data,
        input  issue_ready, cpl_rd
    );

    modport slave (
        input  issue_valid, issue_rd, cpl_valid, cpl_data,
        output issue_ready, cpl_rd
    );

endinterface

// File: rtl/stage3_rd_fifo.sv
// In-order FIFO of destination registers; callers only push when not full
// and only pop when not empty. The head reads as 0 when empty.
module stage3_rd_fifo
    import stage3_load_scoreboard_pkg::*;
#(
    parameter  int DEPTH = SCOREBOARD_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  regidx_t       push_rd,
    input  logic          pop,
    output regidx_t       head_rd,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    regidx_t       mem_q [DEPTH];
    regidx_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for storage, pointers and the occupancy count that tells full from empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_rd;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and count are cleared on reset; stale entries are harmless once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset because the count masks it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_rd = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/stage3_load_scoreboard.sv
// Tracks destinations of in-flight long-latency writes and tells execute
// whether each source operand must stall or can take the completing result.
module stage3_load_scoreboard
    import stage3_load_scoreboard_pkg::*;
#(
    parameter  int DEPTH = SCOREBOARD_DEPTH,
    parameter  int NREGS = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    stage3_load_scoreboard_if.slave  bus,
    input  regidx_t                  rs1_e,
    input  regidx_t                  rs2_e,
    output logic                     stall_rs1,
    output logic                     stall_rs2,
    output logic                     fwd_rs1,
    output logic                     fwd_rs2,
    output word_t                    fwd_data,
    output logic [CW-1:0]            occupancy,
    output logic                     underflow
);

    logic          issue_fire;
    logic          cpl_fire;
    logic          fifo_full;
    logic          fifo_empty;
    regidx_t       head_rd;
    logic [CW-1:0] pend_q [NREGS];
    logic [CW-1:0] pend_d [NREGS];
    logic          underflow_q, underflow_d;
    logic [1:0]    rs1_status;
    logic [1:0]    rs2_status;

    assign issue_fire = bus.issue_valid && !fifo_full;
    assign cpl_fire   = bus.cpl_valid && !fifo_empty;

    stage3_rd_fifo #(
        .DEPTH (DEPTH)
    ) u_rd_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (issue_fire),
        .push_rd (bus.issue_rd),
        .pop     (cpl_fire),
        .head_rd (head_rd),
        .count   (occupancy),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Pending counters: increment then decrement, so a same-register issue and completion cancel.
    always_comb begin
        pend_d = pend_q;
        if (issue_fire && bus.issue_rd != '0) begin
            pend_d[bus.issue_rd] = pend_d[bus.issue_rd] + CW'(1);
        end
        if (cpl_fire && head_rd != '0) begin
            pend_d[head_rd] = pend_d[head_rd] - CW'(1);
        end
        underflow_d = underflow_q | (bus.cpl_valid && fifo_empty);
    end

    // Counters and the sticky underflow flag clear only on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                pend_q[i] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            underflow_q <= underflow_d;
        end
    end

    // Operand hazard decision from registered counters and the live completion.
    always_comb begin
        rs1_status = operand_status(rs1_e,
                                    pend_q[rs1_e] == '0,
                                    pend_q[rs1_e] == CW'(1),
                                    bus.cpl_valid && head_rd == rs1_e);
        rs2_status = operand_status(rs2_e,
                                    pend_q[rs2_e] == '0,
                                    pend_q[rs2_e] == CW'(1),
                                    bus.cpl_valid && head_rd == rs2_e);
    end

    assign stall_rs1       = rs1_status[1];
    assign fwd_rs1         = rs1_status[0];
    assign stall_rs2       = rs2_status[1];
    assign fwd_rs2         = rs2_status[0];
    assign fwd_data        = bus.cpl_data;
    assign bus.cpl_rd      = head_rd;
    assign bus.issue_ready = !fifo_full;
    assign underflow       = underflow_q;

endmodule
